// File: rtl/vtb_traceback_pkg.sv
// Shared constants, FSM encoding and helpers for the Viterbi traceback engine.
package vtb_traceback_pkg;

    // Trellis state width (2^WD_STATE states).
    localparam int unsigned WD_STATE = 8;
    // Survivor-memory page index width (one page per code).
    localparam int unsigned WD_DEPTH = 6;
    // Traceback steps per decoded bit, 1..2^WD_DEPTH-1.
    localparam int unsigned TB_LEN   = 32;
    // Read address width: {page, state}.
    localparam int unsigned WD_ADDR  = WD_DEPTH + WD_STATE;

    // Step count of the final walk step; the step counter shares the page width.
    localparam logic [WD_DEPTH-1:0] TB_LAST = WD_DEPTH'(TB_LEN - 1);

    typedef enum logic [1:0] {
        TB_IDLE = 2'd0,
        TB_READ = 2'd1,
        TB_WAIT = 2'd2,
        TB_EMIT = 2'd3
    } tb_state_e;

    // Previous survivor page, wrapping 0 -> 2^WD_DEPTH-1.
    function automatic logic [WD_DEPTH-1:0] page_dec(input logic [WD_DEPTH-1:0] page);
        return page - WD_DEPTH'(1);
    endfunction

endpackage

// File: rtl/vtb_traceback_if.sv
// Control, compare-stage, survivor-memory and status signals of the traceback engine.
interface vtb_traceback_if;
    import vtb_traceback_pkg::*;

    logic                TB_EN;
    logic [WD_DEPTH-1:0] ACSPage;
    logic [WD_STATE-1:0] BestState;
    logic                BestValid;
    logic                MemRd;
    logic [WD_ADDR-1:0]  MemAddr;
    logic                MemData;
    logic                DecodeBit;
    logic                DecodeValid;
    logic                Busy;
    logic                Overrun;

    // Traceback engine side.
    modport master (
        input  TB_EN, ACSPage, BestState, BestValid, MemData,
        output MemRd, MemAddr, DecodeBit, DecodeValid, Busy, Overrun
    );

    // Control unit / compare stage / survivor memory side.
    modport slave (
        output TB_EN, ACSPage, BestState, BestValid, MemData,
        input  MemRd, MemAddr, DecodeBit, DecodeValid, Busy, Overrun
    );

endinterface

// File: rtl/vtb_traceback.sv
// Viterbi traceback engine: per best-state report, walks the survivor memory back
// TB_LEN pages and emits one decoded bit. All outputs are registered.
module vtb_traceback
    import vtb_traceback_pkg::*;
(
    input logic            CLOCK,
    input logic            Reset,
    vtb_traceback_if.master bus
);

    tb_state_e           fsm_q;
    logic [WD_DEPTH-1:0] page_q;
    logic [WD_STATE-1:0] state_q;
    logic [WD_DEPTH-1:0] step_q;

    logic                mem_rd_q;
    logic [WD_ADDR-1:0]  mem_addr_q;
    logic                decode_bit_q;
    logic                decode_valid_q;
    logic                busy_q;
    logic                overrun_q;

    logic [WD_STATE-1:0] state_nxt;
    logic [WD_DEPTH-1:0] page_nxt;
    logic [WD_DEPTH-1:0] acs_prev;

    // One walk step: shift the survivor bit into the state and move one page back.
    always_comb begin
        state_nxt = {state_q[WD_STATE-2:0], bus.MemData};
        page_nxt  = page_dec(page_q);
        acs_prev  = page_dec(bus.ACSPage);
    end

    // FSM with datapath; outputs are set one edge ahead so they are valid in the target state.
    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            fsm_q          <= TB_IDLE;
            page_q         <= '0;
            state_q        <= '0;
            step_q         <= '0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
            decode_bit_q   <= 1'b0;
            decode_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            mem_rd_q       <= 1'b0;
            decode_valid_q <= 1'b0;

            // A report arriving while busy is dropped; the running walk is untouched.
            if (bus.TB_EN && bus.BestValid && fsm_q != TB_IDLE) begin
                overrun_q <= 1'b1;
            end

            unique case (fsm_q)
                TB_IDLE: begin
                    if (bus.TB_EN && bus.BestValid) begin
                        page_q     <= acs_prev;
                        state_q    <= bus.BestState;
                        step_q     <= '0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {acs_prev, bus.BestState};
                        busy_q     <= 1'b1;
                        fsm_q      <= TB_READ;
                    end
                end
                TB_READ: begin
                    fsm_q <= TB_WAIT;
                end
                TB_WAIT: begin
                    state_q <= state_nxt;
                    page_q  <= page_nxt;
                    step_q  <= step_q + WD_DEPTH'(1);
                    if (step_q == TB_LAST) begin
                        decode_bit_q   <= state_nxt[WD_STATE-1];
                        decode_valid_q <= 1'b1;
                        fsm_q          <= TB_EMIT;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {page_nxt, state_nxt};
                        fsm_q      <= TB_READ;
                    end
                end
                TB_EMIT: begin
                    busy_q <= 1'b0;
                    fsm_q  <= TB_IDLE;
                end
                default: begin
                    fsm_q <= TB_IDLE;
                end
            endcase
        end
    end

    assign bus.MemRd       = mem_rd_q;
    assign bus.MemAddr     = mem_addr_q;
    assign bus.DecodeBit   = decode_bit_q;
    assign bus.DecodeValid = decode_valid_q;
    assign bus.Busy        = busy_q;
    assign bus.Overrun     = overrun_q;

endmodule
